// File: rtl/regfile_pkg.sv
// Shared register-file types and sizes.
// Used by the register file, its write arbiter and the control FSM.
package regfile_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int REG_DATA_W = 16;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
// The pointer moves past the winner only when the grant is taken.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;

  // Scan from the pointer, wrapping, first requester wins.
  always_comb begin
    int j;
    logic found;
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_q) + k) % N;
      if (!found && req_i[j]) begin
        found     = 1'b1;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = IW'(j);
      end
    end
  end

  // Next pointer is one past the winner of a taken grant.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      if (int'(gnt_idx_o) == N - 1) ptr_d = '0;
      else                          ptr_d = gnt_idx_o + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between writeback requesters
// and tracks outstanding claimed writes in a busy scoreboard.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      claim_valid,
  input  logic [ADDR_W-1:0]         claim_addr,
  output logic                      claim_ready,
  output logic [(1<<ADDR_W)-1:0]    busy,
  output logic                      WriteEnable,
  output logic [ADDR_W-1:0]         SelectInput,
  output logic [DATA_W-1:0]         In,
  output logic [15:0]               stall_count
);

  localparam int NREG = 1 << ADDR_W;
  localparam int IW   = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               xfer;
  logic               stalled;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  logic               we_q, we_d;
  logic [ADDR_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0]  in_q, in_d;
  logic [NREG-1:0]    busy_q, busy_d;
  logic [15:0]        stall_q, stall_d;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk_i     (Clock),
    .rst_i     (Reset),
    .req_i     (req_valid),
    .advance_i (xfer),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign req_ready   = Reset ? '0 : gnt;
  assign xfer        = |(req_valid & req_ready);
  assign stalled     = |(req_valid & ~req_ready);
  assign sel_addr    = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign sel_data    = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
  assign claim_ready = ~Reset & claim_valid & ~busy_q[claim_addr];

  // Next-state: write port, scoreboard, saturating stall counter.
  always_comb begin
    we_d    = xfer;
    sel_d   = sel_q;
    in_d    = in_q;
    busy_d  = busy_q;
    stall_d = stall_q;
    if (xfer) begin
      sel_d            = sel_addr;
      in_d             = sel_data;
      busy_d[sel_addr] = 1'b0;
    end
    if (claim_ready) busy_d[claim_addr] = 1'b1;
    if (stalled && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  // State registers; reset drops any accepted-but-unwritten transfer.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      we_q    <= 1'b0;
      sel_q   <= '0;
      in_q    <= '0;
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      we_q    <= we_d;
      sel_q   <= sel_d;
      in_q    <= in_d;
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
  end

  assign WriteEnable = we_q;
  assign SelectInput = sel_q;
  assign In          = in_q;
  assign busy        = busy_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized + directed bench for regfile_write_arbiter
// against a cycle-level reference model.
module tb_regfile_write_arbiter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_ready;
  logic        claim_valid = 1'b0;
  logic [3:0]  claim_addr = '0;
  logic        claim_ready;
  logic [15:0] busy;
  logic        WriteEnable;
  logic [3:0]  SelectInput;
  logic [15:0] In;
  logic [15:0] stall_count;

  always #5 Clock = ~Clock;

  regfile_write_arbiter dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .claim_ready (claim_ready),
    .busy        (busy),
    .WriteEnable (WriteEnable),
    .SelectInput (SelectInput),
    .In          (In),
    .stall_count (stall_count)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s: got %0h expected %0h @%0t",
                 tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int          m_ptr;
  logic [15:0] m_busy;
  logic        m_we;
  logic [3:0]  m_sel;
  logic [15:0] m_in;
  logic [15:0] m_stall;

  task automatic mreset();
    m_ptr = 0; m_busy = '0; m_we = 1'b0;
    m_sel = '0; m_in = '0; m_stall = '0;
  endtask

  // One clock: check registered outputs, drive, check comb
  // outputs, advance the model across the edge.
  task automatic step(input logic rst, input logic [1:0] v,
                      input logic [3:0] a0, input logic [3:0] a1,
                      input logic [15:0] d0, input logic [15:0] d1,
                      input logic cv, input logic [3:0] ca,
                      output logic [1:0] rdy);
    logic [1:0] er;
    logic       ecr;
    int         g;
    check("we", WriteEnable, m_we);
    check("sel", SelectInput, m_sel);
    check("in", In, m_in);
    check("busy", busy, m_busy);
    check("stall", stall_count, m_stall);
    Reset = rst; req_valid = v;
    req_addr = {a1, a0}; req_data = {d1, d0};
    claim_valid = cv; claim_addr = ca;
    #1;
    er = '0; g = -1;
    if (!rst)
      for (int k = 0; k < 2; k++) begin
        int j;
        j = (m_ptr + k) % 2;
        if (g < 0 && v[j]) begin g = j; er[j] = 1'b1; end
      end
    ecr = !rst && cv && !m_busy[ca];
    check("ready", req_ready, er);
    check("claim_ready", claim_ready, ecr);
    rdy = er;
    @(posedge Clock);
    if (rst) mreset();
    else begin
      if ((|(v & ~er)) && m_stall != 16'hFFFF) m_stall++;
      m_we = (g >= 0);
      if (g >= 0) begin
        m_sel = (g == 1) ? a1 : a0;
        m_in  = (g == 1) ? d1 : d0;
        m_busy[m_sel] = 1'b0;
        m_ptr = (g + 1) % 2;
      end
      if (ecr) m_busy[ca] = 1'b1;
    end
    @(negedge Clock);
  endtask

  logic [1:0]  r;
  logic [1:0]  pv;
  logic [3:0]  pa [2];
  logic [15:0] pd [2];

  initial begin
    mreset();
    repeat (2) @(posedge Clock);
    @(negedge Clock);

    // Reset with both requesting, then req0 wins first
    step(1, 2'b11, 4'd1, 4'd2, 16'h11, 16'h22, 1, 4'd3, r);
    step(1, 2'b11, 4'd1, 4'd2, 16'h11, 16'h22, 0, 4'd0, r);
    step(0, 2'b11, 4'd1, 4'd2, 16'h11, 16'h22, 0, 4'd0, r);
    check("first_grant", r, 2'b01);
    step(0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 0, 4'd0, r);

    // Single write, then hold on idle
    step(0, 2'b01, 4'd3, 4'd0, 16'hBEEF, 16'h0, 0, 4'd0, r);
    check("sw_we", WriteEnable, 1'b1);
    check("sw_sel", SelectInput, 4'd3);
    check("sw_in", In, 16'hBEEF);
    step(0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 0, 4'd0, r);
    check("idle_we", WriteEnable, 1'b0);
    check("idle_in", In, 16'hBEEF);

    // Contention: 4 cycles of both valid
    for (int i = 0; i < 4; i++) begin
      step(0, 2'b11, 4'd8, 4'd9, 16'(i), 16'(i + 100),
           0, 4'd0, r);
      check("cont_we", WriteEnable, 1'b1);
    end
    step(0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 0, 4'd0, r);

    // Scoreboard claim / re-claim / clear / re-claim
    step(0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1, 4'd5, r);
    check("b5_set", busy[5], 1'b1);
    step(0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1, 4'd5, r);
    step(0, 2'b01, 4'd5, 4'd0, 16'h55, 16'h0, 0, 4'd0, r);
    check("b5_clr", busy[5], 1'b0);
    step(0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1, 4'd5, r);
    check("b5_reclaim", busy[5], 1'b1);

    // Same-edge claim 7 with write to busy reg 2
    step(0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1, 4'd2, r);
    step(0, 2'b01, 4'd2, 4'd0, 16'h22, 16'h0, 1, 4'd7, r);
    check("mix_b7", busy[7], 1'b1);
    check("mix_b2", busy[2], 1'b0);

    // Mid-op reset after an accepted transfer
    step(0, 2'b11, 4'd1, 4'd4, 16'hA, 16'hB, 1, 4'd9, r);
    step(1, 2'b11, 4'd1, 4'd4, 16'hA, 16'hB, 0, 4'd0, r);
    check("rst_we", WriteEnable, 1'b0);
    check("rst_busy", busy, 16'h0);
    check("rst_stall", stall_count, 16'h0);
    step(0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 0, 4'd0, r);

    // Randomized traffic honouring the hold-until-ready rule
    pv = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int q = 0; q < 2; q++)
        if (!pv[q] && $urandom_range(0, 2) != 0) begin
          pv[q] = 1'b1;
          pa[q] = 4'($urandom);
          pd[q] = 16'($urandom);
        end
      step(($urandom_range(0, 199) == 0), pv,
           pa[0], pa[1], pd[0], pd[1],
           ($urandom_range(0, 2) == 0), 4'($urandom), r);
      pv = pv & ~r;
      if (Reset) pv = '0;
    end

    // Saturation of the stall counter
    for (int i = 0; i < 65600; i++)
      step(0, 2'b11, 4'($urandom), 4'($urandom),
           16'($urandom), 16'($urandom), 0, 4'd0, r);
    check("stall_sat", stall_count, 16'hFFFF);
    step(0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 0, 4'd0, r);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
